// File: rtl/missile_pool.sv
// Projectile pool: spawns missiles at the ship on fire, moves them each frame in
// fixed point, retires them on collision, off-screen or lifetime, and draws them.
module missile_pool #(
  parameter int SHOT_AMOUNT = 7,
  parameter int PIXEL_WIDTH = 11,
  parameter int RGB_WIDTH = 8,
  parameter logic [RGB_WIDTH-1:0] MISSILE_COLOR = 8'h1F,
  parameter int FRAC_BITS = 6,
  parameter int X_SPEED = 0,
  parameter int Y_SPEED = -256,
  parameter int X_OFFSET = 15,
  parameter int Y_OFFSET = 0,
  parameter int MISSILE_W = 2,
  parameter int MISSILE_H = 5,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int LIFETIME_FRAMES = 0,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic                                 shooting_pulse,
  input  logic                                 startOfFrame,
  input  logic                                 collision,
  input  logic [PIXEL_WIDTH-1:0]               pixelX,
  input  logic [PIXEL_WIDTH-1:0]               pixelY,
  input  logic [PIXEL_WIDTH-1:0]               spaceShip_X,
  input  logic [PIXEL_WIDTH-1:0]               spaceShip_Y,
  output logic                                 missileDR,
  output logic [RGB_WIDTH-1:0]                 missileRGB,
  output logic [$clog2(SHOT_AMOUNT+1)-1:0]     active_count,
  output logic                                 shot_fired,
  output logic                                 missile_hit
);

  localparam int PW  = PIXEL_WIDTH + FRAC_BITS + 1;
  localparam int CW  = $clog2(SHOT_AMOUNT + 1);
  localparam int CDW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int LW  = (LIFETIME_FRAMES > 0) ? $clog2(LIFETIME_FRAMES + 1) : 1;

  localparam logic signed [PW-1:0] X_SPEED_S  = PW'(X_SPEED);
  localparam logic signed [PW-1:0] Y_SPEED_S  = PW'(Y_SPEED);
  localparam logic signed [PW-1:0] X_OFFSET_S = PW'(X_OFFSET);
  localparam logic signed [PW-1:0] Y_OFFSET_S = PW'(Y_OFFSET);
  localparam logic signed [PW-1:0] W_S        = PW'(MISSILE_W);
  localparam logic signed [PW-1:0] H_S        = PW'(MISSILE_H);
  localparam logic signed [PW-1:0] X_MAX      = PW'(SCREEN_W - 1);
  localparam logic signed [PW-1:0] Y_MAX      = PW'(SCREEN_H - 1);
  localparam logic [LW-1:0]        LIFE_LIM   = LW'(LIFETIME_FRAMES);
  localparam logic [CDW-1:0]       COOL_LOAD  = CDW'(COOLDOWN_FRAMES);

  typedef enum logic {IDLE, FLYING} slot_state_t;

  logic [SHOT_AMOUNT-1:0] flying_vec, flying_next_vec, hit_vec, collided_vec;
  logic [SHOT_AMOUNT-1:0] idle_vec, fire_sel;
  logic                   fire_accept;
  logic [CDW-1:0]         cool_reg, cool_next;
  logic [CW-1:0]          count_next;

  logic signed [PW-1:0] pix_x, pix_y, ship_x, ship_y, spawn_x, spawn_y;

  assign pix_x   = $signed({{(PW-PIXEL_WIDTH){1'b0}}, pixelX});
  assign pix_y   = $signed({{(PW-PIXEL_WIDTH){1'b0}}, pixelY});
  assign ship_x  = $signed({{(PW-PIXEL_WIDTH){1'b0}}, spaceShip_X});
  assign ship_y  = $signed({{(PW-PIXEL_WIDTH){1'b0}}, spaceShip_Y});
  assign spawn_x = (ship_x + X_OFFSET_S) <<< FRAC_BITS;
  assign spawn_y = (ship_y + Y_OFFSET_S) <<< FRAC_BITS;

  // Eligibility uses the registered state, so a slot retiring this cycle waits one cycle.
  assign idle_vec    = ~flying_vec;
  assign fire_sel    = idle_vec & (~idle_vec + SHOT_AMOUNT'(1));
  assign fire_accept = shooting_pulse && (cool_reg == '0) && (|idle_vec);

  for (genvar gi = 0; gi < SHOT_AMOUNT; gi++) begin : g_slot
    slot_state_t          state_reg, state_next;
    logic signed [PW-1:0] x_reg, x_next, y_reg, y_next;
    logic signed [PW-1:0] x_px, y_px, x_mov, y_mov, x_mov_px, y_mov_px;
    logic [LW-1:0]        life_reg, life_next, life_inc;
    logic                 hit_reg, hit_next, spawn, collided, off_screen, expired;

    assign x_px     = x_reg >>> FRAC_BITS;
    assign y_px     = y_reg >>> FRAC_BITS;
    assign x_mov    = x_reg + X_SPEED_S;
    assign y_mov    = y_reg + Y_SPEED_S;
    assign x_mov_px = x_mov >>> FRAC_BITS;
    assign y_mov_px = y_mov >>> FRAC_BITS;
    assign life_inc = life_reg + LW'(1);

    assign hit_next   = (state_reg == FLYING)
                        && (pix_x >= x_px) && (pix_x < x_px + W_S)
                        && (pix_y >= y_px) && (pix_y < y_px + H_S);
    assign spawn      = fire_accept && fire_sel[gi];
    assign collided   = collision && hit_reg && (state_reg == FLYING);
    assign off_screen = x_mov_px[PW-1] || (x_mov_px > X_MAX)
                        || y_mov_px[PW-1] || (y_mov_px > Y_MAX);
    assign expired    = (LIFETIME_FRAMES != 0) && (life_inc == LIFE_LIM);

    // Spawn only targets IDLE slots and collision only FLYING ones, so the
    // priority order below never has to arbitrate between them on one slot.
    always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      life_next  = life_reg;
      if (spawn) begin
        state_next = FLYING;
        x_next     = spawn_x;
        y_next     = spawn_y;
        life_next  = '0;
      end else if (collided) begin
        state_next = IDLE;
      end else if ((state_reg == FLYING) && startOfFrame) begin
        x_next    = x_mov;
        y_next    = y_mov;
        life_next = life_inc;
        if (off_screen || expired) begin
          state_next = IDLE;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!resetN) begin
        state_reg <= IDLE;
        x_reg     <= '0;
        y_reg     <= '0;
        life_reg  <= '0;
        hit_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        x_reg     <= x_next;
        y_reg     <= y_next;
        life_reg  <= life_next;
        hit_reg   <= hit_next;
      end
    end

    assign flying_vec[gi]      = (state_reg == FLYING);
    assign flying_next_vec[gi] = (state_next == FLYING);
    assign hit_vec[gi]         = hit_reg;
    assign collided_vec[gi]    = collided;
  end

  always_comb begin
    cool_next = cool_reg;
    if (fire_accept) begin
      cool_next = COOL_LOAD;
    end else if (startOfFrame && (cool_reg != '0)) begin
      cool_next = cool_reg - CDW'(1);
    end
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < SHOT_AMOUNT; i++) begin
      count_next = count_next + CW'(flying_next_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cool_reg     <= '0;
      shot_fired   <= 1'b0;
      missile_hit  <= 1'b0;
      active_count <= '0;
    end else begin
      cool_reg     <= cool_next;
      shot_fired   <= fire_accept;
      missile_hit  <= |collided_vec;
      active_count <= count_next;
    end
  end

  assign missileDR  = |hit_vec;
  assign missileRGB = MISSILE_COLOR;

endmodule

// File: tb/tb_missile_pool.sv
// Bench for missile_pool: two configurations driven in lockstep, compared every
// cycle against a slot-array reference model, plus directed scenario checks.
module tb_missile_pool;

  localparam int N = 7;

  logic        clk = 1'b0;
  logic        resetN, shooting_pulse, startOfFrame, collision;
  logic [10:0] pixelX, pixelY, ship_x, ship_y;

  logic       dr_a, shot_a, mhit_a, dr_b, shot_b, mhit_b;
  logic [7:0] rgb_a, rgb_b;
  logic [2:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  missile_pool u_dut_a (
    .clk(clk), .resetN(resetN), .shooting_pulse(shooting_pulse),
    .startOfFrame(startOfFrame), .collision(collision),
    .pixelX(pixelX), .pixelY(pixelY), .spaceShip_X(ship_x), .spaceShip_Y(ship_y),
    .missileDR(dr_a), .missileRGB(rgb_a), .active_count(cnt_a),
    .shot_fired(shot_a), .missile_hit(mhit_a)
  );

  missile_pool #(
    .COOLDOWN_FRAMES(0), .LIFETIME_FRAMES(5), .X_SPEED(0), .Y_SPEED(0)
  ) u_dut_b (
    .clk(clk), .resetN(resetN), .shooting_pulse(shooting_pulse),
    .startOfFrame(startOfFrame), .collision(collision),
    .pixelX(pixelX), .pixelY(pixelY), .spaceShip_X(ship_x), .spaceShip_Y(ship_y),
    .missileDR(dr_b), .missileRGB(rgb_b), .active_count(cnt_b),
    .shot_fired(shot_b), .missile_hit(mhit_b)
  );

  // Reference configuration per instance: cooldown, lifetime, speeds (1/64 px).
  int p_cool[2] = '{8, 0};
  int p_life[2] = '{0, 5};
  int p_xs[2]   = '{0, 0};
  int p_ys[2]   = '{-256, 0};

  bit m_fly[2][N];
  bit m_hit[2][N];
  int m_x[2][N];
  int m_y[2][N];
  int m_life[2][N];
  int m_cool[2];
  int exp_dr[2], exp_shot[2], exp_mhit[2], exp_cnt[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_px(input int v);
    if (v >= 0) return v / 64;
    return -((-v + 63) / 64);
  endfunction

  task automatic model_step();
    bit old_fly[N];
    bit new_hit[N];
    int pick, fx, fy, px, py;
    for (int d = 0; d < 2; d++) begin
      if (!resetN) begin
        for (int i = 0; i < N; i++) begin
          m_fly[d][i] = 0; m_hit[d][i] = 0;
          m_x[d][i] = 0; m_y[d][i] = 0; m_life[d][i] = 0;
        end
        m_cool[d] = 0;
        exp_dr[d] = 0; exp_shot[d] = 0; exp_mhit[d] = 0; exp_cnt[d] = 0;
      end else begin
        px = int'(pixelX);
        py = int'(pixelY);
        for (int i = 0; i < N; i++) begin
          old_fly[i] = m_fly[d][i];
          fx = floor_px(m_x[d][i]);
          fy = floor_px(m_y[d][i]);
          new_hit[i] = old_fly[i] && px >= fx && px < fx + 2 && py >= fy && py < fy + 5;
        end
        exp_mhit[d] = 0;
        for (int i = 0; i < N; i++) begin
          if (old_fly[i]) begin
            if (collision && m_hit[d][i]) begin
              m_fly[d][i] = 0;
              exp_mhit[d] = 1;
            end else if (startOfFrame) begin
              m_x[d][i] += p_xs[d];
              m_y[d][i] += p_ys[d];
              m_life[d][i]++;
              fx = floor_px(m_x[d][i]);
              fy = floor_px(m_y[d][i]);
              if (fx < 0 || fx > 639 || fy < 0 || fy > 479) m_fly[d][i] = 0;
              if (p_life[d] != 0 && m_life[d][i] == p_life[d]) m_fly[d][i] = 0;
            end
          end
        end
        pick = -1;
        for (int i = N - 1; i >= 0; i--) if (!old_fly[i]) pick = i;
        exp_shot[d] = (shooting_pulse && m_cool[d] == 0 && pick >= 0) ? 1 : 0;
        if (exp_shot[d] == 1) begin
          m_fly[d][pick]  = 1;
          m_x[d][pick]    = (int'(ship_x) + 15) * 64;
          m_y[d][pick]    = int'(ship_y) * 64;
          m_life[d][pick] = 0;
          m_cool[d]       = p_cool[d];
        end else if (startOfFrame && m_cool[d] > 0) begin
          m_cool[d]--;
        end
        exp_dr[d]  = 0;
        exp_cnt[d] = 0;
        for (int i = 0; i < N; i++) begin
          m_hit[d][i] = new_hit[i];
          if (new_hit[i]) exp_dr[d] = 1;
          if (m_fly[d][i]) exp_cnt[d]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("dr_a",   int'(dr_a),   exp_dr[0]);
    check_val("shot_a", int'(shot_a), exp_shot[0]);
    check_val("mhit_a", int'(mhit_a), exp_mhit[0]);
    check_val("cnt_a",  int'(cnt_a),  exp_cnt[0]);
    check_val("rgb_a",  int'(rgb_a),  'h1F);
    check_val("dr_b",   int'(dr_b),   exp_dr[1]);
    check_val("shot_b", int'(shot_b), exp_shot[1]);
    check_val("mhit_b", int'(mhit_b), exp_mhit[1]);
    check_val("cnt_b",  int'(cnt_b),  exp_cnt[1]);
    check_val("rgb_b",  int'(rgb_b),  'h1F);
    shooting_pulse = 1'b0;
    startOfFrame   = 1'b0;
    collision      = 1'b0;
  endtask

  task automatic cyc(input bit f, input bit s, input bit c);
    shooting_pulse = f;
    startOfFrame   = s;
    collision      = c;
    tick();
  endtask

  task automatic set_pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
  endtask

  task automatic set_ship(input int x, input int y);
    ship_x = 11'(x);
    ship_y = 11'(y);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0; shooting_pulse = 1'b0; startOfFrame = 1'b0; collision = 1'b0;
    set_pix(0, 0);
    set_ship(0, 0);
    tick();
    tick();
    check_val("rst_cnt_a", int'(cnt_a), 0);
    check_val("rst_dr_a",  int'(dr_a),  0);
    resetN = 1'b1;

    // Fire and move: (115,400) after spawn, Y=388 after three frames.
    set_ship(100, 400);
    cyc(1, 0, 0);
    check_val("fire_shot", int'(shot_a), 1);
    check_val("fire_cnt",  int'(cnt_a),  1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0);
      cyc(0, 0, 0);
    end
    set_pix(115, 388); cyc(0, 0, 0); check_val("y388_in",   int'(dr_a), 1);
    set_pix(115, 387); cyc(0, 0, 0); check_val("y387_out",  int'(dr_a), 0);
    set_pix(116, 392); cyc(0, 0, 0); check_val("corner_in", int'(dr_a), 1);
    set_pix(117, 388); cyc(0, 0, 0); check_val("x117_out",  int'(dr_a), 0);
    set_pix(0, 0);

    // Cooldown: only the fire after the 8th frame is accepted.
    do_reset();
    cyc(1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      check_val("cool_shot", int'(shot_a), (k == 8) ? 1 : 0);
    end
    check_val("cool_cnt", int'(cnt_a), 2);

    // Collision on slot0 (115,368) with slot1 at (115,400) untouched.
    set_pix(115, 368); cyc(0, 0, 0); check_val("col_dr", int'(dr_a), 1);
    set_pix(0, 0);     cyc(0, 0, 1);
    check_val("col_hit", int'(mhit_a), 1);
    check_val("col_cnt", int'(cnt_a),  1);
    // Collision coinciding with a frame pulse.
    set_pix(115, 400); cyc(0, 0, 0); check_val("colsof_dr", int'(dr_a), 1);
    set_pix(0, 0);     cyc(0, 1, 1);
    check_val("colsof_hit", int'(mhit_a), 1);
    check_val("colsof_cnt", int'(cnt_a),  0);

    // Off-screen on first frame (A); lifetime of 5 frames (B).
    do_reset();
    set_ship(100, 2);
    cyc(1, 0, 0);
    check_val("off_spawn", int'(cnt_a), 1);
    cyc(0, 1, 0);
    check_val("off_gone", int'(cnt_a), 0);
    check_val("life_1",   int'(cnt_b), 1);
    for (int k = 2; k <= 5; k++) begin
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      check_val("life_k", int'(cnt_b), (k < 5) ? 1 : 0);
    end

    // Full pool on B, retire slot3 by collision, refill.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_ship(20 + 40 * i, 100);
      cyc(1, 0, 0);
      check_val("full_shot", int'(shot_b), (i < 7) ? 1 : 0);
    end
    check_val("full_cnt", int'(cnt_b), 7);
    set_pix(155, 100); cyc(0, 0, 0); check_val("full_dr", int'(dr_b), 1);
    set_pix(0, 0);     cyc(0, 0, 1);
    check_val("full_hit", int'(mhit_b), 1);
    check_val("full_c6",  int'(cnt_b),  6);
    set_ship(500, 200);
    cyc(1, 0, 0);
    check_val("refill_shot", int'(shot_b), 1);
    check_val("refill_cnt",  int'(cnt_b),  7);
    set_pix(515, 200); cyc(0, 0, 0); check_val("refill_dr", int'(dr_b), 1);

    // Reset with missiles in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_ship(60 + 50 * i, 300);
      cyc(1, 0, 0);
    end
    check_val("mid_cnt4", int'(cnt_b), 4);
    set_pix(75, 300);
    resetN = 1'b0;
    cyc(1, 1, 1);
    check_val("mid_cnt",  int'(cnt_b),  0);
    check_val("mid_dr",   int'(dr_b),   0);
    check_val("mid_shot", int'(shot_b), 0);
    check_val("mid_rgb",  int'(rgb_b),  'h1F);
    resetN = 1'b1;

    // Randomized traffic against the model.
    set_ship(150, 400);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(19) == 0) set_ship(int'($urandom_range(400, 50)), int'($urandom_range(470, 100)));
      if ($urandom_range(4) == 0)
        set_pix(int'($urandom_range(639)), int'($urandom_range(479)));
      else
        set_pix(int'(ship_x) + int'($urandom_range(20, 10)), int'(ship_y) + 5 - int'($urandom_range(100, 0)));
      resetN = ($urandom_range(399) != 0);
      cyc($urandom_range(2) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
